// File: rtl/fcp_pl_tx_pkg.sv
// rtl/fcp_pl_tx_pkg.sv - shared FCP physical-layer transmit constants, types and CRC step
package fcp_pl_tx_pkg;

  localparam logic       PL_TX_PING = 1'b0;
  localparam logic       PL_TX_RESP = 1'b1;
  localparam logic [7:0] CRC8_POLY  = 8'h39;
  localparam logic [7:0] FCP_ACK    = 8'h08;
  localparam logic [7:0] FCP_NACK   = 8'h03;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PING     = 3'd1;
  localparam logic [2:0] ST_SYNC_HI  = 3'd2;
  localparam logic [2:0] ST_SYNC_LO  = 3'd3;
  localparam logic [2:0] ST_BITS     = 3'd4;
  localparam logic [2:0] ST_END_PING = 3'd5;

  typedef enum logic [1:0] {
    BSEL_HI    = 2'd0,
    BSEL_LO    = 2'd1,
    BSEL_CRC   = 2'd2,
    BSEL_FINAL = 2'd3
  } byte_sel_t;

  // One MSB-first step of the serial CRC-8 LFSR.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/fcp_pl_tx_if.sv
// rtl/fcp_pl_tx_if.sv - logical-layer to physical-layer transmit request/status bundle
interface fcp_pl_tx_if;
  logic        pl_tx_en;
  logic        pl_tx_type;
  logic        pl_tx_afc;
  logic [15:0] pl_tx_data;
  logic        tx_abort;
  logic        tx_done;
  logic        tx_busy;

  modport master (
    output pl_tx_en, pl_tx_type, pl_tx_afc, pl_tx_data, tx_abort,
    input  tx_done, tx_busy
  );

  modport slave (
    input  pl_tx_en, pl_tx_type, pl_tx_afc, pl_tx_data, tx_abort,
    output tx_done, tx_busy
  );
endinterface

// File: rtl/fcp_crc8_ser.sv
// rtl/fcp_crc8_ser.sv - serial CRC-8 (poly 0x39, init 0) stepped once per data bit
module fcp_crc8_ser
  import fcp_pl_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/fcp_pl_tx.sv
// rtl/fcp_pl_tx.sv - FCP slave PHY transmitter: UI-timed PING / RESPOND serializer on D-
module fcp_pl_tx
  import fcp_pl_tx_pkg::*;
#(
  parameter int UI_CYCLES = 80,
  parameter int PING_UI   = 16,
  parameter int SYNC_UI   = 2
) (
  input  logic          clk,
  input  logic          rstn,
  fcp_pl_tx_if.slave    ll,
  output logic          dp_tx_out,
  output logic          dp_tx_oe
);

  localparam int UIW = $clog2(UI_CYCLES);
  localparam logic [UIW-1:0] UI_LAST   = UIW'(UI_CYCLES - 1);
  localparam logic [4:0]     PING_LAST = 5'(PING_UI - 1);
  localparam logic [4:0]     SYNC_LAST = 5'(SYNC_UI - 1);

  logic [2:0]     state;
  logic [UIW-1:0] ui_cnt;
  logic [4:0]     len_cnt;
  logic [3:0]     bit_cnt;
  byte_sel_t      byte_sel;
  logic [7:0]     shift;
  logic           par;
  logic           lat_afc;
  logic [15:0]    lat_data;
  logic [7:0]     crc;

  logic ui_wrap;
  logic start;
  logic frame_end;
  logic crc_en;

  assign ui_wrap   = (ui_cnt == UI_LAST);
  assign start     = (state == ST_IDLE) && ll.pl_tx_en && !ll.tx_abort;
  assign frame_end = ((state == ST_PING) || (state == ST_END_PING)) && ui_wrap
                     && (len_cnt == PING_LAST);
  assign crc_en    = (state == ST_BITS) && ui_wrap && (bit_cnt != 4'd8)
                     && ((byte_sel == BSEL_HI) || (byte_sel == BSEL_LO));

  fcp_crc8_ser u_crc (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (start),
    .en     (crc_en),
    .bit_in (shift[7]),
    .crc    (crc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ui_cnt <= '0;
    end else if ((state == ST_IDLE) || ll.tx_abort || ui_wrap) begin
      ui_cnt <= '0;
    end else begin
      ui_cnt <= ui_cnt + UIW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      len_cnt  <= 5'd0;
      bit_cnt  <= 4'd0;
      byte_sel <= BSEL_HI;
      shift    <= 8'h00;
      par      <= 1'b0;
      lat_afc  <= 1'b0;
      lat_data <= 16'h0000;
    end else if (ll.tx_abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ll.pl_tx_en) begin
            lat_afc  <= ll.pl_tx_afc;
            lat_data <= ll.pl_tx_data;
            len_cnt  <= 5'd0;
            if (ll.pl_tx_type == PL_TX_PING) begin
              state <= ST_PING;
            end else begin
              state    <= ST_SYNC_HI;
              byte_sel <= (ll.pl_tx_data[15:8] != 8'h00) ? BSEL_HI : BSEL_LO;
            end
          end
        end
        ST_PING, ST_END_PING: begin
          if (ui_wrap) begin
            if (len_cnt == PING_LAST) state <= ST_IDLE;
            else                      len_cnt <= len_cnt + 5'd1;
          end
        end
        ST_SYNC_HI: begin
          if (ui_wrap) begin
            if (len_cnt == SYNC_LAST) state <= ST_SYNC_LO;
            else                      len_cnt <= len_cnt + 5'd1;
          end
        end
        ST_SYNC_LO: begin
          if (ui_wrap) begin
            if (byte_sel == BSEL_FINAL) begin
              state   <= ST_END_PING;
              len_cnt <= 5'd0;
            end else begin
              state   <= ST_BITS;
              bit_cnt <= 4'd0;
              par     <= 1'b1;
              case (byte_sel)
                BSEL_HI: shift <= lat_data[15:8];
                BSEL_LO: shift <= lat_data[7:0];
                default: shift <= crc;
              endcase
            end
          end
        end
        ST_BITS: begin
          // Nine UIs per byte: eight data bits, then the odd-parity bit.
          if (ui_wrap) begin
            if (bit_cnt == 4'd8) begin
              state   <= ST_SYNC_HI;
              len_cnt <= 5'd0;
              case (byte_sel)
                BSEL_HI:  byte_sel <= BSEL_LO;
                BSEL_LO:  byte_sel <= lat_afc ? BSEL_FINAL : BSEL_CRC;
                default:  byte_sel <= BSEL_FINAL;
              endcase
            end else begin
              shift   <= {shift[6:0], 1'b0};
              par     <= par ^ shift[7];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dp_tx_out = 1'b0;
    case (state)
      ST_PING, ST_END_PING, ST_SYNC_HI: dp_tx_out = 1'b1;
      ST_BITS: dp_tx_out = (bit_cnt == 4'd8) ? par : shift[7];
      default: dp_tx_out = 1'b0;
    endcase
  end

  assign dp_tx_oe   = (state != ST_IDLE);
  assign ll.tx_busy = (state != ST_IDLE);
  assign ll.tx_done = frame_end && !ll.tx_abort;

endmodule

// File: tb/tb_fcp_pl_tx.sv
// tb/tb_fcp_pl_tx.sv - scoreboard bench for fcp_pl_tx (per-UI line bits and frame lengths)
module tb_fcp_pl_tx;
  import fcp_pl_tx_pkg::*;

  localparam int UI  = 4;
  localparam int PUI = 16;
  localparam int SUI = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic dp_tx_out;
  logic dp_tx_oe;

  fcp_pl_tx_if ifc ();

  fcp_pl_tx #(.UI_CYCLES(UI), .PING_UI(PUI), .SYNC_UI(SUI)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ll        (ifc.slave),
    .dp_tx_out (dp_tx_out),
    .dp_tx_oe  (dp_tx_oe)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit sb_bits[$];
  int sb_len[$];
  int cyc = 0;
  bit prev_oe = 1'b0;
  int done_cnt = 0;
  bit exp_bit;
  int exp_len;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc_model(input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? hi : lo;
      if (k == 0 && hi == 8'h00) continue;
      c = c ^ b;
      for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h39) : (c << 1);
    end
    return c;
  endfunction

  task automatic push_ui(input bit v, input int n);
    for (int i = 0; i < n; i++) sb_bits.push_back(v);
  endtask

  task automatic push_sync();
    push_ui(1'b1, SUI);
    push_ui(1'b0, 1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_sync();
    for (int i = 7; i >= 0; i--) push_ui(b[i], 1);
    push_ui(~^b, 1);
  endtask

  task automatic expect_frame(input bit typ, input bit afc, input logic [15:0] d);
    int start;
    start = sb_bits.size();
    if (typ == 1'b0) begin
      push_ui(1'b1, PUI);
    end else begin
      if (d[15:8] != 8'h00) push_byte(d[15:8]);
      push_byte(d[7:0]);
      if (!afc) push_byte(crc_model(d[15:8], d[7:0]));
      push_sync();
      push_ui(1'b1, PUI);
    end
    sb_len.push_back((sb_bits.size() - start) * UI);
  endtask

  task automatic pulse_en(input bit typ, input bit afc, input logic [15:0] d);
    ifc.pl_tx_type = typ;
    ifc.pl_tx_afc  = afc;
    ifc.pl_tx_data = d;
    ifc.pl_tx_en   = 1'b1;
    @(posedge clk);
    #1 ifc.pl_tx_en = 1'b0;
  endtask

  task automatic send(input bit typ, input bit afc, input logic [15:0] d);
    expect_frame(typ, afc, d);
    pulse_en(typ, afc, d);
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (ifc.tx_done) break;
    end
    chk({tag, "_done_seen"}, (k < 600), 1);
    @(negedge clk);
    chk({tag, "_oe_after"}, dp_tx_oe, 0);
    chk({tag, "_busy_after"}, ifc.tx_busy, 0);
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      prev_oe = 1'b0;
    end else begin
      if (dp_tx_oe) begin
        if (!prev_oe) cyc = 0;
        if (cyc % UI == 1) begin
          if (sb_bits.size() == 0) begin
            chk("line_extra_ui", 1, 0);
          end else begin
            exp_bit = sb_bits.pop_front();
            chk("line_bit", dp_tx_out, exp_bit);
          end
        end
        cyc++;
      end
      if (ifc.tx_done) begin
        done_cnt++;
        if (sb_len.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          exp_len = sb_len.pop_front();
          chk("frame_len", cyc, exp_len);
        end
      end
      prev_oe = dp_tx_oe;
    end
  end

  initial begin
    int dc;
    ifc.pl_tx_en   = 1'b0;
    ifc.pl_tx_type = 1'b0;
    ifc.pl_tx_afc  = 1'b0;
    ifc.pl_tx_data = 16'h0000;
    ifc.tx_abort   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out", dp_tx_out, 0);
    chk("rst_oe", dp_tx_oe, 0);
    chk("rst_busy", ifc.tx_busy, 0);
    chk("rst_done", ifc.tx_done, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    send(PL_TX_PING, 1'b0, 16'h0000);
    wait_done("ping");

    send(PL_TX_RESP, 1'b0, {8'h00, FCP_ACK});
    wait_done("ack");

    send(PL_TX_RESP, 1'b0, 16'h0801);
    wait_done("read");

    send(PL_TX_RESP, 1'b1, 16'h0008);
    wait_done("afc");

    // Second request mid-frame must not disturb the frame; then back-to-back start.
    send(PL_TX_RESP, 1'b0, 16'h0008);
    repeat (20) @(negedge clk);
    pulse_en(PL_TX_PING, 1'b1, 16'hFFFF);
    wait_done("busy_ign");
    send(PL_TX_PING, 1'b0, 16'h0000);
    wait_done("b2b");

    send(PL_TX_RESP, 1'b0, 16'h0801);
    repeat (30) @(negedge clk);
    chk("abort_pre_busy", ifc.tx_busy, 1);
    ifc.tx_abort = 1'b1;
    @(posedge clk);
    #1 ifc.tx_abort = 1'b0;
    sb_bits.delete();
    sb_len.delete();
    chk("abort_oe", dp_tx_oe, 0);
    chk("abort_out", dp_tx_out, 0);
    chk("abort_busy", ifc.tx_busy, 0);
    dc = done_cnt;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);
    send(PL_TX_PING, 1'b0, 16'h0000);
    wait_done("post_abort");

    send(PL_TX_PING, 1'b0, 16'h0000);
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_out", dp_tx_out, 0);
    chk("arst_oe", dp_tx_oe, 0);
    chk("arst_busy", ifc.tx_busy, 0);
    chk("arst_done", ifc.tx_done, 0);
    sb_bits.delete();
    sb_len.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_idle", ifc.tx_busy, 0);
    send(PL_TX_PING, 1'b0, 16'h0000);
    wait_done("post_rst");

    chk("sb_bits_empty", sb_bits.size(), 0);
    chk("sb_len_empty", sb_len.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
